bp_flush_ctrl: RTL and testbench

BP_FLUSH_CTRL -- requirements
Module: bp_flush_ctrl

---
 rtl/bp_flush_ctrl_pkg.sv | 12 +
 rtl/bp_flush_ctrl.sv | 113 +++++++++++
 tb/tb_bp_flush_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/bp_flush_ctrl_pkg.sv
// Shared types for the branch-predictor flush controller: FSM state encoding.
package bp_flush_ctrl_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = ST_IDLE,
    FLUSH = ST_FLUSH
  } bp_flush_state_t;

endpackage

// File: rtl/bp_flush_ctrl.sv
// Branch-table flush controller: sweeps every line of all ways with clear writes, otherwise passes updates.
// Optional macro BP_FLUSH_AUTO_INIT_EN: run one full flush automatically on the first clock after reset release.
module bp_flush_ctrl
  import bp_flush_ctrl_pkg::*;
#(
  parameter int ENTRIES = 512,  // power of two, >= 2
  parameter int WAYS    = 2,    // 1..8
  localparam int AW     = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_req,
  input  logic            upd_valid,
  input  logic [WAYS-1:0] upd_way,
  input  logic [AW-1:0]   upd_addr,
  output logic [WAYS-1:0] wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic            wr_clear,
  output logic            upd_dropped,
  output logic            predict_block,
  output logic            flush_busy,
  output logic            flush_done
);

  localparam logic [AW-1:0] LAST = AW'(ENTRIES - 1);

  bp_flush_state_t state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic            start;

`ifdef BP_FLUSH_AUTO_INIT_EN
  logic init_q, init_d;
  assign start  = flush_req | init_q;
  assign init_d = 1'b0;
`else
  assign start = flush_req;
`endif

  // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    wr_en       = '0;
    wr_addr     = '0;
    wr_clear    = 1'b0;
    upd_dropped = 1'b0;
    flush_done  = 1'b0;

    case (state_q)
      IDLE: begin
        if (upd_valid && (|upd_way)) begin
          wr_en   = upd_way;
          wr_addr = upd_addr;
        end
        if (start) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        // The clear write owns the RAM port; a concurrent update is discarded.
        wr_en       = '1;
        wr_addr     = cnt_q;
        wr_clear    = 1'b1;
        upd_dropped = upd_valid;
        cnt_d       = cnt_q + AW'(1);
        if (cnt_q == LAST) begin
          flush_done = 1'b1;
          pend_d     = 1'b0;
          if (!(pend_q || flush_req)) state_d = IDLE;
        end else if (flush_req) begin
          pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are forced quiet for as long as reset is held, not just at the edge.
    if (!rst) begin
      wr_en       = '0;
      wr_addr     = '0;
      wr_clear    = 1'b0;
      upd_dropped = 1'b0;
      flush_done  = 1'b0;
    end
  end

  assign flush_busy    = rst && (state_q == FLUSH);
  assign predict_block = flush_busy;

  // NOTE: state registers use non-blocking assignments so all of them sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

`ifdef BP_FLUSH_AUTO_INIT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) init_q <= 1'b1;
    else      init_q <= init_d;
  end
`endif

endmodule

// File: tb/tb_bp_flush_ctrl.sv
// Self-checking bench for bp_flush_ctrl (ENTRIES=8, WAYS=2) against a queue-of-pending-clears reference model.
module tb_bp_flush_ctrl;

  localparam int E  = 8;
  localparam int W  = 2;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush_req = 1'b0;
  logic          upd_valid = 1'b0;
  logic [W-1:0]  upd_way = '0;
  logic [AW-1:0] upd_addr = '0;
  logic [W-1:0]  wr_en;
  logic [AW-1:0] wr_addr;
  logic          wr_clear, upd_dropped, predict_block, flush_busy, flush_done;

  bp_flush_ctrl #(.ENTRIES(E), .WAYS(W)) dut (
    .clk(clk), .rst(rst), .flush_req(flush_req), .upd_valid(upd_valid),
    .upd_way(upd_way), .upd_addr(upd_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_clear(wr_clear), .upd_dropped(upd_dropped), .predict_block(predict_block),
    .flush_busy(flush_busy), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_count = 0;

  // Reference model: addresses still to be cleared, one per cycle, in order.
  int q[$];
  bit init_pend = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, advance model for the coming posedge.
  task automatic step(input bit fr, input bit uv, input logic [W-1:0] uw, input logic [AW-1:0] ua);
    bit busy;
    int sz;
    logic [W-1:0] all_ways;
    @(negedge clk);
    rst       = 1'b1;
    flush_req = fr;
    upd_valid = uv;
    upd_way   = uw;
    upd_addr  = ua;
    #2;
    all_ways = '1;
    busy = (q.size() != 0);
    if (busy) begin
      check("wr_en",    32'(wr_en),   32'(all_ways));
      check("wr_addr",  32'(wr_addr), 32'(q[0]));
      check("wr_clear", 32'(wr_clear), 32'd1);
      check("dropped",  32'(upd_dropped), 32'(uv));
      check("done",     32'(flush_done), 32'(q[0] == E - 1));
    end else begin
      check("wr_en",    32'(wr_en),   uv ? 32'(uw) : 32'd0);
      check("wr_addr",  32'(wr_addr), (uv && uw != 0) ? 32'(ua) : 32'd0);
      check("wr_clear", 32'(wr_clear), 32'd0);
      check("dropped",  32'(upd_dropped), 32'd0);
      check("done",     32'(flush_done), 32'd0);
    end
    check("busy",    32'(flush_busy), 32'(busy));
    check("block",   32'(predict_block), 32'(busy));
    if (flush_done) done_count++;
    sz = q.size();
    if (busy) void'(q.pop_front());
    // A request while one batch (or none) is queued adds a batch; a second pending one saturates.
    if ((fr || init_pend) && sz <= E)
      for (int i = 0; i < E; i++) q.push_back(i);
    init_pend = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst       = 1'b0;
    flush_req = 1'b1;
    upd_valid = 1'b1;
    upd_way   = 2'b01;
    upd_addr  = 3'd5;
    #1;
    check("rst_wr_en",   32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_clear",   32'(wr_clear), 32'd0);
    check("rst_dropped", 32'(upd_dropped), 32'd0);
    check("rst_busy",    32'(flush_busy), 32'd0);
    check("rst_block",   32'(predict_block), 32'd0);
    check("rst_done",    32'(flush_done), 32'd0);
    q.delete();
`ifdef BP_FLUSH_AUTO_INIT_EN
    init_pend = 1'b1;
`else
    init_pend = 1'b0;
`endif
    #5;
  endtask

  function automatic logic [W-1:0] rand_way();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return '0;
    if (r == 1) return '1;
    return W'(1 << $urandom_range(0, W - 1));
  endfunction

  initial begin
    do_reset();
    for (int i = 0; i < 12; i++) step(0, 0, '0, '0);

    // Single update passthrough, then a plain flush with an update dropped mid-sweep.
    step(0, 1, 2'b10, 3'd5);
    done_count = 0;
    step(1, 0, '0, '0);
    for (int i = 0; i < E; i++) step(0, (i == 3), 2'b01, 3'd2);
    step(0, 0, '0, '0);
    check("one_done_pulse", 32'(done_count), 32'd1);

    // Request together with an update in IDLE; second request at cnt=4 chains a second sweep.
    done_count = 0;
    step(1, 1, 2'b01, 3'd6);
    for (int i = 0; i < 2 * E; i++) step((i == 4), 0, '0, '0);
    step(0, 0, '0, '0);
    check("two_done_pulses", 32'(done_count), 32'd2);

    // Request exactly on the completion cycle restarts the sweep.
    step(1, 0, '0, '0);
    for (int i = 0; i < 2 * E + 2; i++) step((i == E - 1), 0, '0, '0);

    // Reset in the middle of a sweep aborts it.
    step(1, 0, '0, '0);
    for (int i = 0; i < 6; i++) step(0, 0, '0, '0);
    do_reset();
    for (int i = 0; i < E + 4; i++) step(0, 1, 2'b10, AW'(i));

    // Random traffic with occasional flushes and resets.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      step($urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1, rand_way(), AW'($urandom_range(0, E - 1)));
    end
    for (int i = 0; i < 3 * E; i++) step(0, 0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
